// File: rtl/zion_riscv_isa_lib_slt_de_stage.sv
// ---------------------------------------------------------------------------
// zion_riscv_isa_lib_slt_de_stage
//
// Decode-side producer for the set-less-than / conditional-branch compare
// unit. Recognises SLT, SLTI, SLTU, SLTIU, BLT, BGE, BLTU and BGEU. For each
// accepted instruction it registers the compare inputs (enable, unsigned
// flag, S1, S2) and the execute-stage side information (rd, branch target,
// result-invert flag). Entries pass through a 2-entry valid/ready skid
// buffer, so oRdy never depends combinationally on iRdy.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   iFlush                synchronous flush of both entries
//   iVld / oRdy           upstream handshake (oRdy = !skid valid)
//   iInstr, iPc           instruction word and its PC
//   iRs1Dat, iRs2Dat      register operands
//   oVld / iRdy           downstream handshake
//   oSltEn, oSltUnsigned  compare enable / unsigned compare
//   oSltS1, oSltS2        compare operands
//   oIsBr, oBrInv         branch flag / invert result (BGE, BGEU)
//   oRd                   destination register (0 for branches)
//   oBrTgt                branch target (0 for non-branches)
// ---------------------------------------------------------------------------
module zion_riscv_isa_lib_slt_de_stage #(
    parameter bit RV64 = 1'b0,
    localparam int CPU_WIDTH = RV64 ? 64 : 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 iFlush,
    input  logic                 iVld,
    output logic                 oRdy,
    input  logic [31:0]          iInstr,
    input  logic [CPU_WIDTH-1:0] iPc,
    input  logic [CPU_WIDTH-1:0] iRs1Dat,
    input  logic [CPU_WIDTH-1:0] iRs2Dat,
    output logic                 oVld,
    input  logic                 iRdy,
    output logic                 oSltEn,
    output logic                 oSltUnsigned,
    output logic [CPU_WIDTH-1:0] oSltS1,
    output logic [CPU_WIDTH-1:0] oSltS2,
    output logic                 oIsBr,
    output logic                 oBrInv,
    output logic [4:0]           oRd,
    output logic [CPU_WIDTH-1:0] oBrTgt
);

    typedef struct packed {
        logic                 en;
        logic                 uns;
        logic [CPU_WIDTH-1:0] s1;
        logic [CPU_WIDTH-1:0] s2;
        logic                 is_br;
        logic                 inv;
        logic [4:0]           rd;
        logic [CPU_WIDTH-1:0] tgt;
    } entry_t;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic                 is_slti;
    logic                 is_sltr;
    logic                 is_br;
    logic [CPU_WIDTH-1:0] imm_i;
    logic [CPU_WIDTH-1:0] imm_b;
    entry_t               dec;

    assign opcode = iInstr[6:0];
    assign funct3 = iInstr[14:12];
    assign funct7 = iInstr[31:25];

    // funct3 010/011 select SLT(I)/SLT(I)U; branches only use the 1xx half
    assign is_slti = (opcode == 7'b0010011) && (funct3[2:1] == 2'b01);
    assign is_sltr = (opcode == 7'b0110011) && (funct7 == 7'b0000000) &&
                     (funct3[2:1] == 2'b01);
    assign is_br   = (opcode == 7'b1100011) && funct3[2];

    assign imm_i = {{(CPU_WIDTH-12){iInstr[31]}}, iInstr[31:20]};
    assign imm_b = {{(CPU_WIDTH-13){iInstr[31]}}, iInstr[31], iInstr[7],
                    iInstr[30:25], iInstr[11:8], 1'b0};

    // rs1/rs2 index fields are resolved upstream; only their data is used here
    logic unused_rs_fields;
    assign unused_rs_fields = ^iInstr[24:15];

    always_comb begin
        dec = '0;
        if (is_slti || is_sltr) begin
            dec.en  = 1'b1;
            dec.uns = funct3[0];
            dec.s1  = iRs1Dat;
            // SLTIU still uses the sign-extended immediate, compared unsigned
            dec.s2  = is_slti ? imm_i : iRs2Dat;
            dec.rd  = iInstr[11:7];
        end else if (is_br) begin
            dec.en    = 1'b1;
            dec.uns   = funct3[1];
            dec.inv   = funct3[0];
            dec.is_br = 1'b1;
            dec.s1    = iRs1Dat;
            dec.s2    = iRs2Dat;
            dec.tgt   = iPc + imm_b;
        end
    end

    // ------------------------------------------------------------------
    // Two-entry skid buffer: main drives the outputs, skid absorbs the
    // beat that arrives while main is stalled.
    // ------------------------------------------------------------------
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_vld_q, main_vld_d;
    logic   skid_vld_q, skid_vld_d;
    logic   accept;
    logic   pop;

    assign oRdy   = !skid_vld_q;
    assign accept = iVld && oRdy;
    assign pop    = main_vld_q && iRdy;

    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (iFlush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (pop) begin
            // skid full implies oRdy=0, so no accept competes with the move
            if (skid_vld_q) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                main_d = dec;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_vld_q) begin
                main_d     = dec;
                main_vld_d = 1'b1;
            end else begin
                skid_d     = dec;
                skid_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign oVld         = main_vld_q;
    assign oSltEn       = main_q.en;
    assign oSltUnsigned = main_q.uns;
    assign oSltS1       = main_q.s1;
    assign oSltS2       = main_q.s2;
    assign oIsBr        = main_q.is_br;
    assign oBrInv       = main_q.inv;
    assign oRd          = main_q.rd;
    assign oBrTgt       = main_q.tgt;

endmodule

// File: tb/tb_zion_riscv_isa_lib_slt_de_stage.sv
// ---------------------------------------------------------------------------
// Bench for zion_riscv_isa_lib_slt_de_stage. An RV32 and an RV64 instance run
// in lockstep on shared control/instruction stimulus; a queue-based model
// of the in-order 2-deep buffer plus an arithmetic decode model supplies
// every expected value.
// ---------------------------------------------------------------------------
module tb_zion_riscv_isa_lib_slt_de_stage;

    typedef struct {
        bit        en;
        bit        uns;
        bit        br;
        bit        inv;
        bit [4:0]  rd;
        bit [63:0] s1;
        bit [63:0] s2;
        bit [63:0] tgt;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        vld;
    logic        rdy;
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] rs1;
    logic [63:0] rs2;

    logic        o32_rdy, o32_vld, o32_en, o32_uns, o32_br, o32_inv;
    logic [4:0]  o32_rd;
    logic [31:0] o32_s1, o32_s2, o32_tgt;
    logic        o64_rdy, o64_vld, o64_en, o64_uns, o64_br, o64_inv;
    logic [4:0]  o64_rd;
    logic [63:0] o64_s1, o64_s2, o64_tgt;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q32[$];
    exp_t q64[$];

    zion_riscv_isa_lib_slt_de_stage #(.RV64(1'b0)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .iFlush(flush), .iVld(vld), .oRdy(o32_rdy),
        .iInstr(instr), .iPc(pc[31:0]), .iRs1Dat(rs1[31:0]), .iRs2Dat(rs2[31:0]),
        .oVld(o32_vld), .iRdy(rdy), .oSltEn(o32_en), .oSltUnsigned(o32_uns),
        .oSltS1(o32_s1), .oSltS2(o32_s2), .oIsBr(o32_br), .oBrInv(o32_inv),
        .oRd(o32_rd), .oBrTgt(o32_tgt)
    );

    zion_riscv_isa_lib_slt_de_stage #(.RV64(1'b1)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .iFlush(flush), .iVld(vld), .oRdy(o64_rdy),
        .iInstr(instr), .iPc(pc), .iRs1Dat(rs1), .iRs2Dat(rs2),
        .oVld(o64_vld), .iRdy(rdy), .oSltEn(o64_en), .oSltUnsigned(o64_uns),
        .oSltS1(o64_s1), .oSltS2(o64_s2), .oIsBr(o64_br), .oBrInv(o64_inv),
        .oRd(o64_rd), .oBrTgt(o64_tgt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Decode rules written as integer arithmetic on the instruction fields.
    function automatic exp_t ref_dec(input bit [31:0] ins, input bit [63:0] p,
                                     input bit [63:0] a, input bit [63:0] b, input int w);
        exp_t      e;
        bit [63:0] mask;
        bit [6:0]  op;
        int        f3;
        bit [6:0]  f7;
        longint    immi;
        longint    immb;
        e    = '{default: 0};
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        op   = ins[6:0];
        f3   = int'(ins[14:12]);
        f7   = ins[31:25];
        immi = longint'(ins[31:20]);
        if (immi >= 2048) immi -= 4096;
        immb = longint'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
        if (immb >= 4096) immb -= 8192;
        if (op == 7'h13 && (f3 == 2 || f3 == 3)) begin
            e.en = 1; e.uns = (f3 == 3); e.rd = ins[11:7];
            e.s1 = a & mask; e.s2 = 64'(immi) & mask;
        end else if (op == 7'h33 && f7 == 0 && (f3 == 2 || f3 == 3)) begin
            e.en = 1; e.uns = (f3 == 3); e.rd = ins[11:7];
            e.s1 = a & mask; e.s2 = b & mask;
        end else if (op == 7'h63 && f3 >= 4) begin
            e.en = 1; e.br = 1; e.uns = (f3 >= 6); e.inv = (f3 == 5 || f3 == 7);
            e.s1 = a & mask; e.s2 = b & mask;
            e.tgt = (p + 64'(immb)) & mask;
        end
        return e;
    endfunction

    function automatic bit [31:0] rand_instr();
        bit [31:0] x;
        int        k;
        x = $urandom;
        k = $urandom_range(0, 9);
        if (k <= 1) begin
            x[6:0] = 7'h13; x[14:12] = 3'($urandom_range(2, 3));
        end else if (k <= 3) begin
            x[6:0] = 7'h33; x[14:12] = 3'($urandom_range(2, 3));
            if ($urandom_range(0, 3) != 0) x[31:25] = 7'h00;
        end else if (k <= 7) begin
            x[6:0] = 7'h63;
        end
        return x;
    endfunction

    function automatic bit [63:0] rand_dat();
        bit [63:0] d;
        d = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) d = 64'($urandom_range(0, 15));
        return d;
    endfunction

    task automatic check_outputs();
        check("rdy32", o32_rdy, q32.size() < 2);
        check("vld32", o32_vld, q32.size() > 0);
        check("rdy64", o64_rdy, q64.size() < 2);
        check("vld64", o64_vld, q64.size() > 0);
        if (q32.size() > 0) begin
            check("en32",  o32_en,  q32[0].en);
            check("uns32", o32_uns, q32[0].uns);
            check("s1_32", o32_s1,  q32[0].s1);
            check("s2_32", o32_s2,  q32[0].s2);
            check("br32",  o32_br,  q32[0].br);
            check("inv32", o32_inv, q32[0].inv);
            check("rd32",  o32_rd,  q32[0].rd);
            check("tgt32", o32_tgt, q32[0].tgt);
        end
        if (q64.size() > 0) begin
            check("en64",  o64_en,  q64[0].en);
            check("uns64", o64_uns, q64[0].uns);
            check("s1_64", o64_s1,  q64[0].s1);
            check("s2_64", o64_s2,  q64[0].s2);
            check("br64",  o64_br,  q64[0].br);
            check("inv64", o64_inv, q64[0].inv);
            check("rd64",  o64_rd,  q64[0].rd);
            check("tgt64", o64_tgt, q64[0].tgt);
        end
    endtask

    // Called at a falling edge: check current outputs, drive the next beat,
    // advance the model across the coming rising edge.
    task automatic step(input bit f, input bit v, input bit r, input bit [31:0] ins,
                        input bit [63:0] p, input bit [63:0] a, input bit [63:0] b);
        bit acc;
        bit popq;
        check_outputs();
        flush = f; vld = v; rdy = r; instr = ins; pc = p; rs1 = a; rs2 = b;
        acc  = v && (q32.size() < 2);
        popq = (q32.size() > 0) && r;
        if (f) begin
            q32.delete(); q64.delete();
        end else begin
            if (popq) begin
                void'(q32.pop_front()); void'(q64.pop_front());
            end
            if (acc) begin
                q32.push_back(ref_dec(ins, p, a, b, 32));
                q64.push_back(ref_dec(ins, p, a, b, 64));
            end
        end
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vld"}, {o32_vld, o64_vld}, 2'b00);
        check({tag, "_rdy"}, {o32_rdy, o64_rdy}, 2'b11);
        check({tag, "_flags"}, {o32_en, o32_uns, o32_br, o32_inv, o64_en, o64_uns, o64_br, o64_inv}, 8'h00);
        check({tag, "_rd"}, {o32_rd, o64_rd}, 10'h000);
        check({tag, "_s1"}, o32_s1 | o64_s1, 64'h0);
        check({tag, "_s2"}, o32_s2 | o64_s2, 64'h0);
        check({tag, "_tgt"}, o32_tgt | o64_tgt, 64'h0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 0; vld = 0; rdy = 0; instr = '0; pc = '0; rs1 = '0; rs2 = '0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // SLTI x5, x1, -1
        step(0, 1, 1, 32'hFFF0A293, 64'h0, 64'h5, 64'h0);
        check("slti_vld", o32_vld, 1'b1);
        check("slti_en",  o32_en, 1'b1);
        check("slti_uns", o32_uns, 1'b0);
        check("slti_s1",  o32_s1, 32'h5);
        check("slti_s2",  o32_s2, 32'hFFFF_FFFF);
        check("slti_rd",  o32_rd, 5'd5);
        check("slti_br",  o32_br, 1'b0);

        // BGEU x1, x2, -8 at PC 4
        step(0, 1, 1, 32'hFE20FCE3, 64'h4, 64'h1, 64'h2);
        check("bgeu_br",  o32_br, 1'b1);
        check("bgeu_inv", o32_inv, 1'b1);
        check("bgeu_uns", o32_uns, 1'b1);
        check("bgeu_tgt", o32_tgt, 32'hFFFF_FFFC);
        check("bgeu_rd",  o32_rd, 5'd0);

        // SLTIU x1, x0, imm 0x800
        step(0, 1, 1, 32'h80003093, 64'h0, 64'h0, 64'h0);
        check("sltiu64_s2",  o64_s2, 64'hFFFF_FFFF_FFFF_F800);
        check("sltiu64_uns", o64_uns, 1'b1);

        // ADD x3, x1, x2 is not recognised
        step(0, 1, 1, 32'h002081B3, 64'h100, 64'h1234, 64'h5678);
        check("add_vld", o32_vld, 1'b1);
        check("add_data", {o32_en, o32_uns, o32_br, o32_inv, o32_rd, o32_s1, o32_s2, o32_tgt}, '0);
        step(0, 0, 1, 32'h0, 64'h0, 64'h0, 64'h0);

        // Back-pressure with A, B, C (SLT x1, x2, x3 with distinct rs1)
        step(0, 1, 0, 32'h003120B3, 64'h0, 64'hA, 64'h0);
        step(0, 1, 0, 32'h003120B3, 64'h0, 64'hB, 64'h0);
        check("bp_rdy_low", o32_rdy, 1'b0);
        check("bp_main_a", o32_s1, 32'hA);
        step(0, 1, 0, 32'h003120B3, 64'h0, 64'hC, 64'h0);
        check("bp_hold_a", o32_s1, 32'hA);
        step(0, 1, 1, 32'h003120B3, 64'h0, 64'hC, 64'h0);
        check("bp_out_b", o32_s1, 32'hB);
        step(0, 1, 1, 32'h003120B3, 64'h0, 64'hC, 64'h0);
        check("bp_out_c", o32_s1, 32'hC);
        step(0, 0, 1, 32'h0, 64'h0, 64'h0, 64'h0);

        // Flush with both entries full plus an incoming beat
        step(0, 1, 0, 32'h003120B3, 64'h0, 64'h11, 64'h0);
        step(0, 1, 0, 32'h003120B3, 64'h0, 64'h22, 64'h0);
        step(1, 1, 0, 32'h003120B3, 64'h0, 64'h33, 64'h0);
        check("flush_vld", o32_vld, 1'b0);
        check("flush_rdy", o32_rdy, 1'b1);
        step(0, 0, 1, 32'h0, 64'h0, 64'h0, 64'h0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0, rand_instr(), rand_dat(), rand_dat(), rand_dat());
        end

        // Asynchronous reset mid-stream
        step(0, 1, 0, 32'hFE20FCE3, 64'h4, 64'h7, 64'h9);
        check("pre_rst_vld", o32_vld, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        q32.delete(); q64.delete();
        flush = 0; vld = 0; rdy = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            step(0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 rand_instr(), rand_dat(), rand_dat(), rand_dat());
        end
        check_outputs();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/zion_riscv_isa_lib_slt_de_stage.md
# zion_riscv_isa_lib_slt_de_stage

Decode-side producer for the set-less-than / conditional-branch execution interface. It accepts one RV32I/RV64I instruction per cycle with its operand data, recognises SLT/SLTI/SLTU/SLTIU and BLT/BGE/BLTU/BGEU, and registers the compare-unit inputs `en`, `unsignedFlg`, `s1` and `s2`. It also registers the side information the execute stage needs: destination register, branch target and the BGE/BGEU result-invert flag. It sits between instruction decode and the SLT execution unit and is pipelined through a 2-entry valid/ready skid buffer.

## Interface
- RV64, default 0: 1 selects RV64 (CPU_WIDTH=64); 0 selects RV32 (CPU_WIDTH=32).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- iFlush  in  1  synchronous flush; empties both entries.
- iVld  in  1  upstream instruction valid.
- oRdy  out  1  ready to upstream; equals !skidVld.
- iInstr  in  32  instruction word.
- iPc  in  CPU_WIDTH  instruction PC.
- iRs1Dat  in  CPU_WIDTH  rs1 register value.
- iRs2Dat  in  CPU_WIDTH  rs2 register value.
- oVld  out  1  downstream valid.
- iRdy  in  1  downstream ready.
- oSltEn  out  1  compare enable; 1 only for a recognised instruction.
- oSltUnsigned  out  1  unsigned compare (SLTU, SLTIU, BLTU, BGEU).
- oSltS1  out  CPU_WIDTH  first compare operand.
- oSltS2  out  CPU_WIDTH  second compare operand.
- oIsBr  out  1  the instruction is a branch.
- oBrInv  out  1  invert the compare result (BGE, BGEU).
- oRd  out  5  destination register; 0 for branches.
- oBrTgt  out  CPU_WIDTH  branch target; 0 for non-branches.

## Operation
- Decode, on `iInstr[6:0]` and `funct3 = iInstr[14:12]`:
  - 0010011 with f3=010 is SLTI; f3=011 is SLTIU.
  - 0110011 with funct7=0000000: f3=010 is SLT; f3=011 is SLTU.
  - 1100011: f3=100 is BLT, 101 is BGE, 110 is BLTU, 111 is BGEU.
- Operands:
  - S1 = rs1 data for every recognised instruction.
  - For SLTI/SLTIU, S2 = I-immediate `iInstr[31:20]` sign-extended to CPU_WIDTH. This includes SLTIU, which compares the sign-extended value unsigned.
  - For register and branch forms, S2 = rs2 data.
- Branch target:
  - B-immediate = `{iInstr[31], iInstr[7], iInstr[30:25], iInstr[11:8], 1'b0}`, sign-extended.
  - oBrTgt = iPc + Bimm, modulo 2^CPU_WIDTH (wrap-around, no overflow flag).
- Unrecognised instruction: the entry is still accepted and passed through with oSltEn=0, oSltUnsigned=0, S1=S2=0, oIsBr=0, oBrInv=0, oRd=0, oBrTgt=0. The masked zero operands make the consumer's compare result 0.
- oRd = `iInstr[11:7]` for the SLT class; 0 otherwise.
- Buffer: a main entry (drives the outputs) and a skid entry.
  - Accept: `iVld & oRdy`.
  - Output pop: `oVld & iRdy`.
  - On accept, if main is empty or popping this cycle, the new entry loads main. Otherwise it loads skid.
  - On pop with skid full, skid moves to main.
  - In-order delivery; no entry is dropped or duplicated.
- Flush:
  - iFlush clears both valid bits that cycle and takes priority over a simultaneous accept; the input beat is discarded.
  - oRdy evaluates to 1 in the cycle after a flush.

## Timing
- Latency: an instruction accepted at edge N appears on the outputs with oVld=1 after edge N, when the buffer was empty.
- Throughput: 1 instruction per cycle while iRdy=1.
- oRdy depends only on the registered skid valid; there is no combinational iRdy-to-oRdy path.
- Output data is stable while `oVld & !iRdy`.
- Reset (async assert, sync release): oVld=0, oRdy=1, and every data output is 0. All payload registers are cleared, not only the valid bits.
- Reset asserted mid-transfer discards both entries immediately.
- Simultaneous accept and pop with skid empty: main reloads and oVld stays 1.
- Both entries full: oRdy=0 and the upstream holds.

## Test plan
- RV32, SLTI `x5, x1, -1` (0xFFF0A293), rs1=0x00000005: next cycle oVld=1, oSltEn=1, oSltUnsigned=0, S1=5, S2=0xFFFFFFFF, oRd=5, oIsBr=0.
- RV32, BGEU `x1, x2, -8` (0xFE20FCE3), PC=0x00000004: oIsBr=1, oBrInv=1, oSltUnsigned=1, oBrTgt=0xFFFFFFFC (wrap), oRd=0.
- RV64, SLTIU with imm=0x800, rs1=0: S2=0xFFFFFFFFFFFFF800 and oSltUnsigned=1.
- Unrecognised ADD (0x002081B3): oVld=1, oSltEn=0, and all data outputs are 0.
- Back-pressure: iRdy=0 with 3 consecutive valid inputs A, B, C.
  - A is in main and B in skid; oRdy=0 from the cycle after B is accepted, and C is held.
  - Release iRdy: the outputs are A, B, C in consecutive cycles.
- Reset and flush:
  - With both entries full, iFlush=1 plus iVld=1 gives oVld=0 and oRdy=1 next cycle, and the flushed input is never output.
  - Asserting rst_n=0 mid-stream zeroes all outputs asynchronously, without waiting for a clock edge.
